// File: rtl/core_pkg.sv
// Shared core constants and register-file types.
package core_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/reg_word.sv
// Single W-bit storage word with load enable and async active-low clear.
module reg_word #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // load d when enabled, otherwise hold; reset clears
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// Integer register file: NREGS x XLEN, one write port, two registered read
// ports with write-to-read forwarding and per-port stall. x0 is hardwired 0.
module reg_file_2r1w
   import core_pkg::*;
(
   input  logic     clk,
   input  logic     n_rst,
   input  logic     we,
   input  reg_idx_t waddr,
   input  xword_t   wdata,
   input  logic     ren_a,
   input  reg_idx_t raddr_a,
   output xword_t   rdata_a,
   output logic     rvalid_a,
   input  logic     ren_b,
   input  reg_idx_t raddr_b,
   output xword_t   rdata_b,
   output logic     rvalid_b
);

   xword_t           regs [NREGS];
   logic [NREGS-1:0] wen;
   xword_t           rd_next_a;
   xword_t           rd_next_b;

   // x0 has no storage; out-of-range indices never match any enable bit
   // so such writes fall on the floor
   always_comb begin
      wen = '0;
      for (int i = 1; i < NREGS; i++)
         wen[i] = we && (waddr == reg_idx_t'(i));
   end

   assign regs[0] = '0;

   for (genvar i = 1; i < NREGS; i++) begin : g_reg
      reg_word #(.W(XLEN)) u_word (
         .clk   (clk),
         .n_rst (n_rst),
         .en    (wen[i]),
         .d     (wdata),
         .q     (regs[i])
      );
   end

   // Read select: x0 and out-of-range read 0; a same-cycle write to the
   // index wins over the stored (stale) value.
   function automatic xword_t rd_sel(input reg_idx_t ra, input logic w_en,
                                     input reg_idx_t wa, input xword_t wd,
                                     input xword_t stored);
      if (ra == '0 || 32'(ra) >= NREGS) return '0;
      else if (w_en && wa == ra)        return wd;
      else                              return stored;
   endfunction

   // per-port next read data
   always_comb begin
      rd_next_a = rd_sel(raddr_a, we, waddr, wdata, regs[raddr_a]);
      rd_next_b = rd_sel(raddr_b, we, waddr, wdata, regs[raddr_b]);
   end

   // read data holds while the port is stalled (ren low)
   reg_word #(.W(XLEN)) u_rd_a (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (ren_a),
      .d     (rd_next_a),
      .q     (rdata_a)
   );

   reg_word #(.W(XLEN)) u_rd_b (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (ren_b),
      .d     (rd_next_b),
      .q     (rdata_b)
   );

   // valid flags mark the cycle after an accepted read
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
      end else begin
         rvalid_a <= ren_a;
         rvalid_b <= ren_b;
      end
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
module tb_reg_file_2r1w;

   logic        clk;
   logic        n_rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        ren_a;
   logic [4:0]  raddr_a;
   logic [31:0] rdata_a;
   logic        rvalid_a;
   logic        ren_b;
   logic [4:0]  raddr_b;
   logic [31:0] rdata_b;
   logic        rvalid_b;

   int n_chk;
   int n_err;

   reg_file_2r1w dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .ren_a    (ren_a),
      .raddr_a  (raddr_a),
      .rdata_a  (rdata_a),
      .rvalid_a (rvalid_a),
      .ren_b    (ren_b),
      .raddr_b  (raddr_b),
      .rdata_b  (rdata_b),
      .rvalid_b (rvalid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; ren_a = 1'b0; ren_b = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      idle();
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      n_rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      ren_a = 1'b0; raddr_a = '0; ren_b = 1'b0; raddr_b = '0;
      tick(); tick();
      n_rst = 1'b1;
      tick();

      // 1. async reset clears outputs immediately, then every index reads 0
      wr(5'd3, 32'hAAAA_0003);
      ren_a = 1'b1; raddr_a = 5'd3; ren_b = 1'b1; raddr_b = 5'd3;
      tick();
      chk("pre_rst_a", rdata_a, 32'hAAAA_0003);
      chk("pre_rst_b", rdata_b, 32'hAAAA_0003);
      #2 n_rst = 1'b0;
      #1;
      chk("rst_rdata_a", rdata_a, 32'h0);
      chk("rst_rdata_b", rdata_b, 32'h0);
      chk("rst_rvalid_a", {31'h0, rvalid_a}, 32'h0);
      chk("rst_rvalid_b", {31'h0, rvalid_b}, 32'h0);
      idle();
      tick();
      n_rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ren_a = 1'b1; raddr_a = 5'(i);
         ren_b = 1'b1; raddr_b = 5'(31 - i);
         tick();
         chk("rst_all_a", rdata_a, 32'h0);
         chk("rst_all_b", rdata_b, 32'h0);
      end
      idle();
      tick();

      // 2. write then read with one-cycle latency
      wr(5'd5, 32'hDEAD_BEEF);
      ren_a = 1'b1; raddr_a = 5'd5;
      tick();
      chk("rd_x5", rdata_a, 32'hDEAD_BEEF);
      chk("rd_x5_vld", {31'h0, rvalid_a}, 32'h1);
      idle();

      // 3. forwarding: write and read x7 in the same cycle
      we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
      ren_b = 1'b1; raddr_b = 5'd7;
      tick();
      chk("fwd_x7", rdata_b, 32'h1234_5678);
      chk("fwd_vld_b", {31'h0, rvalid_b}, 32'h1);
      chk("fwd_vld_a", {31'h0, rvalid_a}, 32'h0);
      // overwrite while reading: must see new, not stale
      we = 1'b1; waddr = 5'd7; wdata = 32'h0F0F_0F0F;
      ren_b = 1'b1; raddr_b = 5'd7;
      tick();
      chk("fwd_new_x7", rdata_b, 32'h0F0F_0F0F);
      idle();
      ren_a = 1'b1; raddr_a = 5'd7;
      tick();
      chk("stored_x7", rdata_a, 32'h0F0F_0F0F);
      idle();

      // 4. x0 ignores writes and always reads 0, forward case included
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      ren_a = 1'b1; raddr_a = 5'd0; ren_b = 1'b1; raddr_b = 5'd0;
      tick();
      chk("x0_fwd_a", rdata_a, 32'h0);
      chk("x0_fwd_b", rdata_b, 32'h0);
      we = 1'b0;
      tick();
      chk("x0_a", rdata_a, 32'h0);
      chk("x0_b", rdata_b, 32'h0);
      idle();

      // both ports same index, distinct values on other regs
      wr(5'd9, 32'hCAFE_0009);
      wr(5'd31, 32'h8000_0031);
      ren_a = 1'b1; raddr_a = 5'd9; ren_b = 1'b1; raddr_b = 5'd9;
      tick();
      chk("same_a", rdata_a, 32'hCAFE_0009);
      chk("same_b", rdata_b, 32'hCAFE_0009);
      raddr_a = 5'd31; raddr_b = 5'd5;
      tick();
      chk("x31_a", rdata_a, 32'h8000_0031);
      chk("x5_b", rdata_b, 32'hDEAD_BEEF);
      idle();

      // 5. stall: rdata_a holds while x5 is rewritten
      ren_a = 1'b1; raddr_a = 5'd5;
      tick();
      chk("stall_pre", rdata_a, 32'hDEAD_BEEF);
      ren_a = 1'b0;
      we = 1'b1; waddr = 5'd5; wdata = 32'h0000_0001;
      tick();
      chk("stall_hold", rdata_a, 32'hDEAD_BEEF);
      chk("stall_vld", {31'h0, rvalid_a}, 32'h0);
      idle();
      ren_a = 1'b1; raddr_a = 5'd5;
      tick();
      chk("stall_after", rdata_a, 32'h0000_0001);
      idle();

      // 6. reset pulse mid-stream between back-to-back writes
      we = 1'b1; waddr = 5'd10; wdata = 32'h1010_1010;
      tick();
      waddr = 5'd11; wdata = 32'h1111_1111;
      tick();
      waddr = 5'd12; wdata = 32'h1212_1212;
      #2 n_rst = 1'b0; we = 1'b0;
      #3 n_rst = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         ren_a = 1'b1; raddr_a = 5'(i);
         tick();
         chk("rst_mid_all", rdata_a, 32'h0);
      end
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
